// File: rtl/load_unit_if.sv
// Load-unit bus bundle: load-buffer request, BRAM read port and CDB broadcast.
// The load unit sits on the slave side; the surrounding core (or bench) is master.
interface load_unit_if #(
    parameter int unsigned ROB_IX_WIDTH = 3
);
    logic                    flush_in;
    logic                    valid_in;
    logic [31:0]             addr_in;
    logic [ROB_IX_WIDTH-1:0] rob_ix_in;
    logic [2:0]              funct3_in;
    logic                    ready_out;
    logic [31:0]             mem_addr_out;
    logic                    mem_re_out;
    logic [31:0]             mem_data_in;
    logic                    cdb_valid_out;
    logic [31:0]             cdb_data_out;
    logic [ROB_IX_WIDTH-1:0] cdb_rob_ix_out;
    logic                    cdb_exc_out;
    logic                    cdb_ready_in;

    modport slave (
        input  flush_in, valid_in, addr_in, rob_ix_in, funct3_in,
        input  mem_data_in, cdb_ready_in,
        output ready_out, mem_addr_out, mem_re_out,
        output cdb_valid_out, cdb_data_out, cdb_rob_ix_out, cdb_exc_out
    );

    modport master (
        output flush_in, valid_in, addr_in, rob_ix_in, funct3_in,
        output mem_data_in, cdb_ready_in,
        input  ready_out, mem_addr_out, mem_re_out,
        input  cdb_valid_out, cdb_data_out, cdb_rob_ix_out, cdb_exc_out
    );
endinterface

// File: rtl/load_unit.sv
// Single-outstanding load unit: fixed-latency BRAM read, byte/half/word
// alignment with sign/zero extension, and CDB broadcast with valid/ready.
module load_unit #(
    parameter int unsigned ROB_IX_WIDTH = 3,
    parameter int unsigned MEM_LATENCY  = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    load_unit_if.slave   bus
);
    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state, next_state;
    logic [CNT_W-1:0]        cnt;
    logic [31:0]             mem_addr;
    logic [31:0]             cdb_data;
    logic [ROB_IX_WIDTH-1:0] cdb_rob_ix;
    logic                    cdb_exc;
    logic [1:0]              offset;
    logic [2:0]              funct3;
    logic                    accept;
    logic                    capture;
    logic                    fault;
    logic [7:0]              sel_byte;
    logic [15:0]             sel_half;
    logic [31:0]             extracted;

    always_comb begin
        fault = 1'b0;
        case (bus.funct3_in)
            3'd0, 3'd4: fault = 1'b0;
            3'd1, 3'd5: fault = bus.addr_in[0];
            3'd2:       fault = (bus.addr_in[1:0] != 2'b00);
            default:    fault = 1'b1;
        endcase
    end

    always_comb begin
        sel_byte  = bus.mem_data_in[{offset, 3'b000} +: 8];
        sel_half  = bus.mem_data_in[{offset[1], 4'b0000} +: 16];
        extracted = bus.mem_data_in;
        case (funct3)
            3'd0:    extracted = {{24{sel_byte[7]}}, sel_byte};
            3'd4:    extracted = {24'd0, sel_byte};
            3'd1:    extracted = {{16{sel_half[15]}}, sel_half};
            3'd5:    extracted = {16'd0, sel_half};
            default: extracted = bus.mem_data_in;
        endcase
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.valid_in && !bus.flush_in) begin
                    accept     = 1'b1;
                    next_state = fault ? RESP : ISSUE;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                if (bus.cdb_ready_in) next_state = IDLE;
            end
        endcase
        // Flush overrides everything, including a coincident grant or data capture.
        if (bus.flush_in) begin
            next_state = IDLE;
            capture    = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_addr   <= '0;
            cdb_data   <= '0;
            cdb_rob_ix <= '0;
            cdb_exc    <= 1'b0;
            offset     <= '0;
            funct3     <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                mem_addr   <= {bus.addr_in[31:2], 2'b00};
                cdb_rob_ix <= bus.rob_ix_in;
                offset     <= bus.addr_in[1:0];
                funct3     <= bus.funct3_in;
                cdb_exc    <= fault;
                cdb_data   <= '0;
            end
            if (state == ISSUE) begin
                cnt <= CNT_W'(MEM_LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                cdb_data <= extracted;
                cdb_exc  <= 1'b0;
            end
        end
    end

    assign bus.ready_out      = (state == IDLE);
    assign bus.mem_re_out     = (state == ISSUE);
    assign bus.mem_addr_out   = mem_addr;
    assign bus.cdb_valid_out  = (state == RESP);
    assign bus.cdb_data_out   = cdb_data;
    assign bus.cdb_rob_ix_out = cdb_rob_ix;
    assign bus.cdb_exc_out    = cdb_exc;
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Memory-access stage directly downstream of the load buffer in the Tomasulo superscalar core.
- Accepts one ready load (effective byte address, ROB index, funct3), reads the data BRAM with fixed latency, and aligns and extends the result.
- Broadcasts the result on the common data bus (CDB) with valid/ready handshake to the CDB arbiter.
- Single outstanding load; ROB flush squashes the in-flight load.

Parameters:
- ROB_IX_WIDTH, 3, width of ROB entry index.
- MEM_LATENCY, 2, cycles from mem_re_out high to mem_data_in valid (must be >= 1).

Ports:
- clk_in  input  1  clock; all state updates on its rising edge.
- rst_in  input  1  synchronous, active-high reset.
- flush_in  input  1  ROB misprediction flush; squashes in-flight load.
- valid_in  input  1  load buffer presents a request.
- addr_in  input  32  effective byte address.
- rob_ix_in  input  ROB_IX_WIDTH  ROB entry of the load.
- funct3_in  input  3  0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
- ready_out  output  1  unit can accept a request (combinational, high only in IDLE).
- mem_addr_out  output  32  word-aligned byte address ({addr[31:2],2'b00}).
- mem_re_out  output  1  BRAM read strobe.
- mem_data_in  input  32  BRAM read word, little-endian.
- cdb_valid_out  output  1  result valid on CDB.
- cdb_data_out  output  32  extended load result.
- cdb_rob_ix_out  output  ROB_IX_WIDTH  ROB entry being completed.
- cdb_exc_out  output  1  misaligned or illegal-funct3 fault.
- cdb_ready_in  input  1  CDB arbiter grant.

Behaviour:
- Reset: state IDLE; mem_re_out=0, mem_addr_out=0, cdb_valid_out=0, cdb_data_out=0, cdb_rob_ix_out=0, cdb_exc_out=0, latency counter=0. Reset mid-operation drops the load with no CDB output.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: ready_out=1. If valid_in && !flush_in, latch addr, rob_ix and funct3.
  - Fault (LW with addr[1:0]!=0; LH/LHU with addr[0]!=0; funct3 in {3,6,7}) -> RESP with cdb_exc_out=1, cdb_data_out=0. No memory read.
  - Otherwise -> ISSUE.
- ISSUE: mem_re_out=1 for exactly this one cycle, mem_addr_out driven. Counter loads MEM_LATENCY-1 -> WAIT.
- WAIT: counter decrements each cycle. When the counter is 0, mem_data_in is valid that cycle. Extract and extend it into cdb_data_out, set cdb_exc_out=0 -> RESP.
- Extraction:
  - LB/LBU use byte addr[1:0] (byte 0 = bits 7:0).
  - LH/LHU use half addr[1] (half 0 = bits 15:0).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- RESP: cdb_valid_out=1 with data, rob_ix and exc held stable until cdb_ready_in=1. Handshake cycle -> IDLE; cdb_valid_out=0 the next cycle.
- Latency (no fault, immediate grant): accept at cycle T, mem_re_out at T+1, data at T+1+MEM_LATENCY, cdb_valid_out at T+2+MEM_LATENCY. Faults: cdb_valid_out at T+1.
- No pipelining; the next accept is possible the cycle after the handshake.
- flush_in has priority in every state:
  - next state IDLE, cdb_valid_out=0 next cycle, no CDB broadcast of the squashed load;
  - a request offered with flush_in high is not accepted;
  - a late mem_data_in arriving after a flush is ignored.
- flush_in coincident with cdb_ready_in in RESP: the handshake counts as completed (ROB discards it); state IDLE.
- ready_out is low in ISSUE, WAIT and RESP; the load buffer holds the request.

Test Plan:
- Memory word at 0x100 = 0x8899AABB; LW addr 0x100, rob 5, accepted at cycle 0, grant held high -> mem_re_out at cycle 1, cdb_valid_out at cycle 4 with data 0x8899AABB, rob_ix 5, exc 0.
- Same word; LB addr 0x103 -> 0xFFFFFF88; LBU 0x103 -> 0x00000088; LH 0x102 -> 0xFFFF8899; LHU 0x100 -> 0x0000AABB.
- LW addr 0x102, rob 3 -> no mem_re_out; cdb_valid_out next cycle with exc=1, data 0, rob_ix 3. Same for funct3=7 at 0x100.
- LW accepted, cdb_ready_in held low 5 cycles in RESP -> cdb_valid_out, data and rob_ix stable all 5 cycles; ready_out=0. Grant -> ready_out=1 the next cycle.
- flush_in pulsed during WAIT -> IDLE next cycle, no cdb_valid_out ever for that load. A new LW issued immediately after completes normally.
- rst_in asserted in RESP -> all outputs return to reset values next cycle; ready_out=1.
